cacheline_adapter: RTL

- Sits directly downstream of the data cache's cacheline (dfp) port and upstream of the burst memory model.
- Converts one 256-bit line read or write into a 4-beat x 64-bit burst.
- Returns refilled lines to the cache with a one-cycle valid pulse.
- Holds exactly one outstanding transaction.

---
 rtl/cacheline_adapter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// Bridges one 256-bit cacheline read/write to a 4-beat x 64-bit memory burst, one transaction at a time.
// Optional CACHELINE_ADAPTER_CRIT_WORD_EN: read bursts start at the requested beat and wrap.
module cacheline_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic                  dfp_ready,
  output logic [31:0]           dfp_raddr,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_rvalid,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid,
  output logic [2:0]            dbg_state
);

  // Handshakes: a dfp request transfers on a rising edge where (dfp_read|dfp_write) && dfp_ready;
  // a bmem request/beat transfers on an edge where (bmem_read|bmem_write) && bmem_ready;
  // a returning beat transfers on any edge with bmem_rvalid (no back-pressure).
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST      = CW'(BURST_LEN - 1);
  localparam logic [31:0]   LINE_MASK = 32'(LINE_WIDTH / 8 - 1);
`ifdef CACHELINE_ADAPTER_CRIT_WORD_EN
  localparam int            OFF_LO    = $clog2(BEAT_WIDTH / 8);
  localparam int            OFF_HI    = $clog2(LINE_WIDTH / 8);
  localparam logic [31:0]   RD_MASK   = 32'(BEAT_WIDTH / 8 - 1);
`else
  localparam logic [31:0]   RD_MASK   = LINE_MASK;
`endif

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_REQ     = 3'd1,
    S_RD_COLLECT = 3'd2,
    S_RD_DONE    = 3'd3,
    S_WR_BURST   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         slot;

  // Buffer slot for the current read beat; wraps from the requested beat when enabled.
`ifdef CACHELINE_ADAPTER_CRIT_WORD_EN
  assign slot = cnt_q + addr_q[OFF_HI-1:OFF_LO];
`else
  assign slot = cnt_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    dfp_ready  = 1'b0;
    dfp_rvalid = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        dfp_ready = 1'b1;
        if (dfp_write) begin
          addr_d  = dfp_addr & ~LINE_MASK;
          line_d  = dfp_wdata;
          cnt_d   = '0;
          state_d = S_WR_BURST;
        end else if (dfp_read) begin
          addr_d  = dfp_addr & ~RD_MASK;
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = S_RD_COLLECT;
        end
      end
      S_RD_COLLECT: begin
        // Beats tagged with another burst's address are dropped without counting.
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          line_d[BEAT_WIDTH*slot +: BEAT_WIDTH] = bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            rdata_d = line_d;
            state_d = S_RD_DONE;
          end
        end
      end
      S_RD_DONE: begin
        dfp_rvalid = 1'b1;
        state_d    = S_IDLE;
      end
      S_WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[BEAT_WIDTH*cnt_q +: BEAT_WIDTH];
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dfp_rdata = rdata_q;
  assign dfp_raddr = addr_q & ~LINE_MASK;
  assign dbg_state = state_q;

endmodule
